// File: rtl/wave_cmd_pkg.sv
// Shared types for the waveform command sequencer.
// Opcodes, waveform codes, FSM states and frame-length lookup.
package wave_cmd_pkg;

  typedef enum logic [7:0] {
    OP_SET_WAVE = 8'h01,
    OP_SET_FREQ = 8'h02,
    OP_SET_AMP  = 8'h03,
    OP_ENABLE   = 8'h04,
    OP_DISABLE  = 8'h05
  } opcode_t;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    SQUARE = 2'd1,
    TRI    = 2'd2,
    SAW    = 2'd3
  } wave_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  // Unknown opcodes report 0 like the no-payload ones; callers
  // must check ENABLE/DISABLE explicitly.
  function automatic logic [1:0] payload_len(input logic [7:0] op);
    case (op)
      OP_SET_WAVE: return 2'd1;
      OP_SET_AMP:  return 2'd1;
      OP_SET_FREQ: return 2'd2;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/wave_cmd_ctrl.sv
// Command sequencer: parses strobed SPI bytes into opcode frames
// and atomically commits waveform generator configuration.
module wave_cmd_ctrl
  import wave_cmd_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [15:0] FREQ_RESET     = 16'h0100,
  parameter logic [7:0]  AMP_RESET      = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd_byte,
  input  logic        cmd_valid,
  input  logic        frame_active,
  output logic [1:0]  wave_sel,
  output logic [15:0] freq_word,
  output logic [7:0]  amplitude,
  output logic        gen_enable,
  output logic        cfg_update,
  output logic        err,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES);

  state_t        state;
  logic [7:0]    op_q;
  logic [1:0]    cnt;
  logic [15:0]   stage;
  logic [CW-1:0] tmo;
  logic          byte_ok;
  logic [15:0]   stage_nx;

  assign byte_ok  = cmd_valid & frame_active;
  assign stage_nx = {stage[7:0], cmd_byte};
  assign busy     = (state == ST_PAYLOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= 8'h00;
      cnt        <= 2'd0;
      stage      <= 16'h0000;
      tmo        <= '0;
      wave_sel   <= SINE;
      freq_word  <= FREQ_RESET;
      amplitude  <= AMP_RESET;
      gen_enable <= 1'b0;
      cfg_update <= 1'b0;
      err        <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (byte_ok) begin
            unique case (1'b1)
              cmd_byte == OP_ENABLE: begin
                gen_enable <= 1'b1;
                cfg_update <= 1'b1;
              end
              cmd_byte == OP_DISABLE: begin
                gen_enable <= 1'b0;
                cfg_update <= 1'b1;
              end
              payload_len(cmd_byte) != 2'd0: begin
                op_q  <= cmd_byte;
                cnt   <= payload_len(cmd_byte);
                stage <= 16'h0000;
                tmo   <= '0;
                state <= ST_PAYLOAD;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        ST_PAYLOAD: begin
          // A dropped chip-select outranks any byte in the same cycle;
          // a byte outranks a timeout expiring in the same cycle.
          if (!frame_active) begin
            err   <= 1'b1;
            stage <= 16'h0000;
            state <= ST_IDLE;
          end else if (cmd_valid) begin
            stage <= stage_nx;
            tmo   <= '0;
            cnt   <= cnt - 2'd1;
            if (cnt == 2'd1) begin
              cfg_update <= 1'b1;
              state      <= ST_IDLE;
              unique case (1'b1)
                op_q == OP_SET_WAVE: wave_sel  <= stage_nx[1:0];
                op_q == OP_SET_AMP:  amplitude <= stage_nx[7:0];
                default:             freq_word <= stage_nx;
              endcase
            end
          end else if (tmo == TMO_MAX) begin
            err   <= 1'b1;
            stage <= 16'h0000;
            state <= ST_IDLE;
          end else begin
            tmo <= tmo + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_cmd_ctrl.sv
// Directed bench for wave_cmd_ctrl.
// Short timeout so the abort path is reachable quickly.
module tb_wave_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd_byte;
  logic        cmd_valid;
  logic        frame_active;
  logic [1:0]  wave_sel;
  logic [15:0] freq_word;
  logic [7:0]  amplitude;
  logic        gen_enable;
  logic        cfg_update;
  logic        err;
  logic        busy;

  int total = 0;
  int bad = 0;
  int n_upd = 0;
  int n_err = 0;
  int u0, e0, k;

  always #5 clk = ~clk;

  wave_cmd_ctrl #(
    .TIMEOUT_CYCLES(16),
    .FREQ_RESET(16'h0100),
    .AMP_RESET(8'h80)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_byte(cmd_byte),
    .cmd_valid(cmd_valid),
    .frame_active(frame_active),
    .wave_sel(wave_sel),
    .freq_word(freq_word),
    .amplitude(amplitude),
    .gen_enable(gen_enable),
    .cfg_update(cfg_update),
    .err(err),
    .busy(busy)
  );

  always @(posedge clk) begin
    #1;
    if (cfg_update) n_upd++;
    if (err) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    cmd_byte  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cmd_byte = 8'h00;
    cmd_valid = 1'b0;
    frame_active = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_wave", 32'(wave_sel), 32'h0);
    chk("rst_freq", 32'(freq_word), 32'h0100);
    chk("rst_amp", 32'(amplitude), 32'h80);
    chk("rst_en", 32'(gen_enable), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_upd", 32'(cfg_update), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    idle(1000);
    chk("quiet_upd", 32'(n_upd), 32'h0);
    chk("quiet_err", 32'(n_err), 32'h0);

    // Strobe with CS inactive in IDLE is silently dropped
    send(8'h7F);
    idle(1);
    chk("nocs_err", 32'(n_err), 32'h0);

    // SET_FREQ
    frame_active = 1'b1;
    u0 = n_upd;
    send(8'h02);
    chk("freq_busy1", 32'(busy), 32'h1);
    send(8'h12);
    chk("freq_busy2", 32'(busy), 32'h1);
    chk("freq_partial", 32'(freq_word), 32'h0100);
    send(8'h34);
    chk("freq_word", 32'(freq_word), 32'h1234);
    chk("freq_upd", 32'(cfg_update), 32'h1);
    chk("freq_busy3", 32'(busy), 32'h0);
    idle(2);
    chk("freq_npulse", 32'(n_upd - u0), 32'h1);

    // Back-to-back commands in one frame
    u0 = n_upd;
    e0 = n_err;
    send(8'h01); send(8'h03);
    send(8'h04);
    send(8'h03); send(8'h40);
    idle(2);
    chk("b2b_wave", 32'(wave_sel), 32'h3);
    chk("b2b_en", 32'(gen_enable), 32'h1);
    chk("b2b_amp", 32'(amplitude), 32'h40);
    chk("b2b_npulse", 32'(n_upd - u0), 32'h3);
    chk("b2b_nerr", 32'(n_err - e0), 32'h0);

    // CS drop mid-payload
    u0 = n_upd;
    e0 = n_err;
    send(8'h02); send(8'hAB);
    frame_active = 1'b0;
    @(negedge clk);
    chk("cs_err", 32'(err), 32'h1);
    chk("cs_busy", 32'(busy), 32'h0);
    chk("cs_freq", 32'(freq_word), 32'h1234);
    idle(2);
    chk("cs_nerr", 32'(n_err - e0), 32'h1);
    chk("cs_nupd", 32'(n_upd - u0), 32'h0);

    // Timeout: err 17 cycles after the 0xAB strobe
    frame_active = 1'b1;
    send(8'h02);
    @(negedge clk);
    cmd_byte = 8'hAB;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #2;
      if (err) begin
        k = i;
        break;
      end
    end
    chk("tmo_delay", 32'(k), 32'd17);
    chk("tmo_freq", 32'(freq_word), 32'h1234);
    chk("tmo_busy", 32'(busy), 32'h0);

    // Final byte in the expiry cycle wins
    e0 = n_err;
    send(8'h02);
    @(negedge clk);
    cmd_byte = 8'hAB;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    cmd_byte = 8'hCD;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    #1;
    chk("race_freq", 32'(freq_word), 32'hABCD);
    chk("race_upd", 32'(cfg_update), 32'h1);
    idle(2);
    chk("race_nerr", 32'(n_err - e0), 32'h0);

    // Illegal opcode
    send(8'h05);
    chk("dis_en", 32'(gen_enable), 32'h0);
    u0 = n_upd;
    send(8'h7F);
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_upd", 32'(cfg_update), 32'h0);
    chk("bad_wave", 32'(wave_sel), 32'h3);
    chk("bad_freq", 32'(freq_word), 32'hABCD);
    chk("bad_amp", 32'(amplitude), 32'h40);
    chk("bad_en", 32'(gen_enable), 32'h0);
    chk("bad_busy", 32'(busy), 32'h0);
    send(8'h04);
    chk("en_after", 32'(gen_enable), 32'h1);

    // Reset mid-frame
    send(8'h02);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    u0 = n_upd;
    e0 = n_err;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_wave", 32'(wave_sel), 32'h0);
    chk("mr_freq", 32'(freq_word), 32'h0100);
    chk("mr_amp", 32'(amplitude), 32'h80);
    chk("mr_en", 32'(gen_enable), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    idle(3);
    chk("mr_nupd", 32'(n_upd - u0), 32'h0);
    chk("mr_nerr", 32'(n_err - e0), 32'h0);
    send(8'h03); send(8'h10);
    chk("mr_amp2", 32'(amplitude), 32'h10);
    chk("mr_upd2", 32'(cfg_update), 32'h1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
